// File: rtl/clock_divider_monitor_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : clock_divider_monitor_if                                      |
// | Purpose  : Signal bundle between a divider source/observer and the       |
// |            clock_divider_monitor checker.                                |
// | Ports    : i_mon_en     - monitor enable                                 |
// |            i_div_clk    - divided clock under test (sampled as data)     |
// |            i_exp_ratio  - expected division ratio                        |
// |            o_valid      - one-cycle pulse per measured period            |
// |            o_high_cnt   - last high time (ref cycles)                    |
// |            o_low_cnt    - last low time (ref cycles)                     |
// |            o_period     - last period, high + low                        |
// |            o_mismatch   - pulse: period differs from expected ratio      |
// |            o_duty_err   - pulse: high/low differ by more than 1          |
// |            o_locked     - level: consecutive matching periods reached    |
// |            o_stall      - level: sticky no-edge indicator                |
// | Modports : master drives the inputs, slave is the monitor itself.        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface clock_divider_monitor_if #(
  parameter int RATIO_WIDTH = 5
) ();

  logic                   i_mon_en;
  logic                   i_div_clk;
  logic [RATIO_WIDTH-1:0] i_exp_ratio;
  logic                   o_valid;
  logic [RATIO_WIDTH-1:0] o_high_cnt;
  logic [RATIO_WIDTH-1:0] o_low_cnt;
  logic [RATIO_WIDTH:0]   o_period;
  logic                   o_mismatch;
  logic                   o_duty_err;
  logic                   o_locked;
  logic                   o_stall;

  modport master (
    output i_mon_en, i_div_clk, i_exp_ratio,
    input  o_valid, o_high_cnt, o_low_cnt, o_period,
    input  o_mismatch, o_duty_err, o_locked, o_stall
  );

  modport slave (
    input  i_mon_en, i_div_clk, i_exp_ratio,
    output o_valid, o_high_cnt, o_low_cnt, o_period,
    output o_mismatch, o_duty_err, o_locked, o_stall
  );

endinterface
`default_nettype wire

// File: rtl/clock_divider_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : clock_divider_monitor                                         |
// | Purpose  : Measures high time, low time and period of a divided clock in |
// |            reference-clock cycles, compares the period with the          |
// |            expected ratio and reports lock, mismatch, duty error, stall. |
// | Ports    : i_ref_clk - reference clock (only clock)                      |
// |            i_rst_n   - synchronous active-low reset                      |
// |            mon       - clock_divider_monitor_if.slave bundle             |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module clock_divider_monitor #(
  parameter int RATIO_WIDTH = 5,
  parameter int LOCK_COUNT  = 4
) (
  input  wire logic               i_ref_clk,
  input  wire logic               i_rst_n,
  clock_divider_monitor_if.slave  mon
);

  localparam int LW = $clog2(LOCK_COUNT + 1);
  localparam logic [RATIO_WIDTH-1:0] c_cnt_max  = {RATIO_WIDTH{1'b1}};
  localparam logic [LW-1:0]          c_lock_max = LW'(LOCK_COUNT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_t;

  state_t                 r_state;
  logic                   r_s1;
  logic                   r_s2;
  logic [RATIO_WIDTH-1:0] r_hi_cnt;
  logic [RATIO_WIDTH-1:0] r_lo_cnt;
  logic [LW-1:0]          r_lock_cnt;
  logic                   r_valid;
  logic [RATIO_WIDTH-1:0] r_high_out;
  logic [RATIO_WIDTH-1:0] r_low_out;
  logic [RATIO_WIDTH:0]   r_period;
  logic                   r_mismatch;
  logic                   r_duty_err;
  logic                   r_locked;
  logic                   r_stall;

  logic                   w_rise;
  logic                   w_fall;
  logic [RATIO_WIDTH:0]   w_sum;
  logic [RATIO_WIDTH-1:0] w_diff;
  logic                   w_duty_bad;
  logic                   w_cmp_en;
  logic                   w_match;
  logic [LW-1:0]          w_lock_inc;

  assign w_rise     = r_s1 & ~r_s2;
  assign w_fall     = ~r_s1 & r_s2;
  assign w_sum      = {1'b0, r_hi_cnt} + {1'b0, r_lo_cnt};
  assign w_diff     = (r_hi_cnt >= r_lo_cnt) ? (r_hi_cnt - r_lo_cnt) : (r_lo_cnt - r_hi_cnt);
  // A difference of exactly 1 is the normal shape of an odd ratio.
  assign w_duty_bad = (w_diff > RATIO_WIDTH'(1));
  // Ratios 0 and 1 mean the divider is bypassed; nothing meaningful to compare.
  assign w_cmp_en   = (mon.i_exp_ratio >= RATIO_WIDTH'(2));
  assign w_match    = (w_sum == {1'b0, mon.i_exp_ratio});
  assign w_lock_inc = (r_lock_cnt == c_lock_max) ? r_lock_cnt : (r_lock_cnt + 1'b1);

  always_ff @(posedge i_ref_clk) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_s1       <= 1'b0;
      r_s2       <= 1'b0;
      r_hi_cnt   <= '0;
      r_lo_cnt   <= '0;
      r_lock_cnt <= '0;
      r_valid    <= 1'b0;
      r_high_out <= '0;
      r_low_out  <= '0;
      r_period   <= '0;
      r_mismatch <= 1'b0;
      r_duty_err <= 1'b0;
      r_locked   <= 1'b0;
      r_stall    <= 1'b0;
    end else begin
      // Synchroniser runs regardless of enable so re-enable sees true edges.
      r_s1       <= mon.i_div_clk;
      r_s2       <= r_s1;
      r_valid    <= 1'b0;
      r_mismatch <= 1'b0;
      r_duty_err <= 1'b0;

      if (!mon.i_mon_en) begin
        r_state    <= S_IDLE;
        r_hi_cnt   <= '0;
        r_lo_cnt   <= '0;
        r_lock_cnt <= '0;
        r_locked   <= 1'b0;
        r_stall    <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_rise) begin
              r_state  <= S_HIGH;
              r_hi_cnt <= RATIO_WIDTH'(1);
            end
          end

          S_HIGH: begin
            if (w_fall) begin
              r_state  <= S_LOW;
              r_lo_cnt <= RATIO_WIDTH'(1);
            end else if (r_hi_cnt == c_cnt_max) begin
              // Saturated without an edge: abandon the period rather than wrap.
              r_state    <= S_IDLE;
              r_stall    <= 1'b1;
              r_lock_cnt <= '0;
              r_locked   <= 1'b0;
            end else begin
              r_hi_cnt <= r_hi_cnt + 1'b1;
            end
          end

          S_LOW: begin
            if (w_rise) begin
              r_state    <= S_HIGH;
              r_hi_cnt   <= RATIO_WIDTH'(1);
              r_valid    <= 1'b1;
              r_high_out <= r_hi_cnt;
              r_low_out  <= r_lo_cnt;
              r_period   <= w_sum;
              r_stall    <= 1'b0;
              r_duty_err <= w_duty_bad;
              if (!w_cmp_en) begin
                r_lock_cnt <= '0;
                r_locked   <= 1'b0;
              end else if (w_match) begin
                r_lock_cnt <= w_lock_inc;
                r_locked   <= (w_lock_inc == c_lock_max);
              end else begin
                r_mismatch <= 1'b1;
                r_lock_cnt <= '0;
                r_locked   <= 1'b0;
              end
            end else if (r_lo_cnt == c_cnt_max) begin
              r_state    <= S_IDLE;
              r_stall    <= 1'b1;
              r_lock_cnt <= '0;
              r_locked   <= 1'b0;
            end else begin
              r_lo_cnt <= r_lo_cnt + 1'b1;
            end
          end

          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign mon.o_valid    = r_valid;
  assign mon.o_high_cnt = r_high_out;
  assign mon.o_low_cnt  = r_low_out;
  assign mon.o_period   = r_period;
  assign mon.o_mismatch = r_mismatch;
  assign mon.o_duty_err = r_duty_err;
  assign mon.o_locked   = r_locked;
  assign mon.o_stall    = r_stall;

endmodule
`default_nettype wire

// File: tb/tb_clock_divider_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_clock_divider_monitor                                      |
// | Purpose  : Directed self-checking bench for clock_divider_monitor.       |
// |            A pattern generator drives i_div_clk with programmable        |
// |            high/low lengths; expected values are hand-computed.          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_clock_divider_monitor;

  logic clk;
  logic rst_n;

  clock_divider_monitor_if #(.RATIO_WIDTH(5)) mon_if ();

  clock_divider_monitor #(
    .RATIO_WIDTH (5),
    .LOCK_COUNT  (4)
  ) u_dut (
    .i_ref_clk (clk),
    .i_rst_n   (rst_n),
    .mon       (mon_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Pattern generator state; only the generator writes i_div_clk.
  int g_hi    = 2;
  int g_lo    = 2;
  int g_ph    = 0;
  bit g_run   = 1'b0;
  bit g_level = 1'b0;

  always @(negedge clk) begin
    if (g_run) begin
      mon_if.i_div_clk = (g_ph < g_hi);
      g_ph = (g_ph + 1) % (g_hi + g_lo);
    end else begin
      mon_if.i_div_clk = g_level;
      g_ph = 0;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input int max_cyc, output int waited, output bit got);
    got    = 1'b0;
    waited = 0;
    while (!got && waited < max_cyc) begin
      @(negedge clk);
      waited++;
      if (mon_if.o_valid) got = 1'b1;
    end
  endtask

  task automatic wait_stall(input int max_cyc, output int waited, output bit got,
                            output bit saw_valid);
    got       = 1'b0;
    saw_valid = 1'b0;
    waited    = 0;
    while (!got && waited < max_cyc) begin
      @(negedge clk);
      waited++;
      if (mon_if.o_valid) saw_valid = 1'b1;
      if (mon_if.o_stall) got = 1'b1;
    end
  endtask

  task automatic restart(input int hi, input int lo, input int ratio);
    @(negedge clk);
    g_run = 1'b0;
    g_level = 1'b0;
    mon_if.i_mon_en = 1'b0;
    repeat (3) @(negedge clk);
    g_hi = hi;
    g_lo = lo;
    mon_if.i_exp_ratio = 5'(ratio);
    mon_if.i_mon_en = 1'b1;
    g_run = 1'b1;
  endtask

  task automatic check_pub(input string tag, input int per, input int hi, input int lo,
                           input bit mm, input bit de, input bit lk);
    check_val({tag, "_period"}, 32'(mon_if.o_period), 32'(per));
    check_val({tag, "_high"},   32'(mon_if.o_high_cnt), 32'(hi));
    check_val({tag, "_low"},    32'(mon_if.o_low_cnt), 32'(lo));
    check_val({tag, "_mism"},   32'(mon_if.o_mismatch), 32'(mm));
    check_val({tag, "_duty"},   32'(mon_if.o_duty_err), 32'(de));
    check_val({tag, "_lock"},   32'(mon_if.o_locked), 32'(lk));
  endtask

  task automatic check_quiet(input string tag);
    check_val({tag, "_valid"}, 32'(mon_if.o_valid), 0);
    check_val({tag, "_mism"},  32'(mon_if.o_mismatch), 0);
    check_val({tag, "_duty"},  32'(mon_if.o_duty_err), 0);
    check_val({tag, "_lock"},  32'(mon_if.o_locked), 0);
    check_val({tag, "_stall"}, 32'(mon_if.o_stall), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  waited;
    bit  got;
    bit  saw_v;

    rst_n = 1'b0;
    mon_if.i_mon_en = 1'b0;
    mon_if.i_exp_ratio = 5'd4;
    repeat (4) @(negedge clk);

    // Reset state
    check_quiet("rst");
    check_val("rst_high",   32'(mon_if.o_high_cnt), 0);
    check_val("rst_low",    32'(mon_if.o_low_cnt), 0);
    check_val("rst_period", 32'(mon_if.o_period), 0);
    rst_n = 1'b1;

    // 1: ratio 4, 2 high / 2 low
    restart(2, 2, 4);
    for (int i = 0; i < 5; i++) begin
      wait_valid(20, waited, got);
      check_val("t1_got", 32'(got), 1);
      if (i > 0) check_val("t1_gap", 32'(waited), 4);
      check_pub("t1", 4, 2, 2, 1'b0, 1'b0, (i >= 3));
    end

    // 2: ratio 5, 2 high / 3 low, then expected ratio moves to 7
    restart(2, 3, 5);
    for (int i = 0; i < 4; i++) begin
      wait_valid(20, waited, got);
      check_val("t2_got", 32'(got), 1);
      check_pub("t2", 5, 2, 3, 1'b0, 1'b0, (i == 3));
    end
    mon_if.i_exp_ratio = 5'd7;
    wait_valid(20, waited, got);
    check_val("t2b_got", 32'(got), 1);
    check_pub("t2b", 5, 2, 3, 1'b1, 1'b0, 1'b0);

    // 3: ratio 6, 1 high / 5 low -> duty error every period, still locks
    restart(1, 5, 6);
    for (int i = 0; i < 4; i++) begin
      wait_valid(20, waited, got);
      check_val("t3_got", 32'(got), 1);
      check_pub("t3", 6, 1, 5, 1'b0, 1'b1, (i == 3));
    end

    // 4: lock at ratio 4, then hold low until stall, then resume
    restart(2, 2, 4);
    for (int i = 0; i < 4; i++) begin
      wait_valid(20, waited, got);
      check_val("t4_got", 32'(got), 1);
    end
    check_val("t4_locked", 32'(mon_if.o_locked), 1);
    g_run = 1'b0;
    g_level = 1'b0;
    wait_stall(60, waited, got, saw_v);
    check_val("t4_stall_got", 32'(got), 1);
    check_val("t4_stall_late", 32'(waited > 20), 1);
    check_val("t4_no_valid", 32'(saw_v), 0);
    check_val("t4_unlocked", 32'(mon_if.o_locked), 0);
    repeat (5) @(negedge clk);
    check_val("t4_stall_hold", 32'(mon_if.o_stall), 1);
    g_run = 1'b1;
    repeat (2) @(negedge clk);
    check_val("t4_stall_sticky", 32'(mon_if.o_stall), 1);
    wait_valid(20, waited, got);
    check_val("t4_resume_got", 32'(got), 1);
    check_val("t4_stall_clr", 32'(mon_if.o_stall), 0);
    check_pub("t4r", 4, 2, 2, 1'b0, 1'b0, 1'b0);

    // 5a: reset pulsed mid-HIGH on a 4/4 pattern at ratio 8
    restart(4, 4, 8);
    wait_valid(30, waited, got);
    check_val("t5a_got", 32'(got), 1);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_quiet("t5a_rst");
    check_val("t5a_rst_period", 32'(mon_if.o_period), 0);
    check_val("t5a_rst_high", 32'(mon_if.o_high_cnt), 0);
    rst_n = 1'b1;
    wait_valid(40, waited, got);
    check_val("t5a_re_got", 32'(got), 1);
    check_pub("t5a_re", 8, 4, 4, 1'b0, 1'b0, 1'b0);

    // 5b: disable mid-LOW
    repeat (5) @(negedge clk);
    mon_if.i_mon_en = 1'b0;
    @(negedge clk);
    check_quiet("t5b_dis");
    check_val("t5b_hold_period", 32'(mon_if.o_period), 8);
    check_val("t5b_hold_high", 32'(mon_if.o_high_cnt), 4);
    check_val("t5b_hold_low", 32'(mon_if.o_low_cnt), 4);
    wait_valid(10, waited, got);
    check_val("t5b_no_valid", 32'(got), 0);
    mon_if.i_mon_en = 1'b1;
    wait_valid(30, waited, got);
    check_val("t5b_re_got", 32'(got), 1);
    check_pub("t5b_re", 8, 4, 4, 1'b0, 1'b0, 1'b0);

    // Bypass ratio with a toggling clock: publishes, never compares
    restart(2, 2, 0);
    for (int i = 0; i < 5; i++) begin
      wait_valid(20, waited, got);
      check_val("t6a_got", 32'(got), 1);
      check_pub("t6a", 4, 2, 2, 1'b0, 1'b0, 1'b0);
    end

    // 6: ratio 0, clock stuck high after one rise
    @(negedge clk);
    g_run = 1'b0;
    g_level = 1'b0;
    mon_if.i_mon_en = 1'b0;
    repeat (3) @(negedge clk);
    mon_if.i_mon_en = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk);
    g_level = 1'b1;
    wait_stall(60, waited, got, saw_v);
    check_val("t6_stall_got", 32'(got), 1);
    check_val("t6_stall_time", 32'(waited), 34);
    check_val("t6_no_valid", 32'(saw_v), 0);
    check_val("t6_lock", 32'(mon_if.o_locked), 0);
    check_val("t6_mism", 32'(mon_if.o_mismatch), 0);
    repeat (10) @(negedge clk);
    check_val("t6_stall_hold", 32'(mon_if.o_stall), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/clock_divider_monitor.md
Name: clock_divider_monitor

Overview:
Receive-side checker for the team's programmable clock divider. It samples a divided clock in the reference-clock domain and measures its high time, low time and period in reference-clock cycles. It compares the period against the expected ratio and reports per-period results, lock, mismatch, duty error and stall. It sits beside the divider in the clock-generation subsystem as a self-check and debug monitor.

Parameters:
RATIO_WIDTH, 5, width of the expected-ratio input; the half-period counters are RATIO_WIDTH bits wide.
LOCK_COUNT, 4, number of consecutive matching periods required before o_locked asserts (at least 1).

Ports:
i_ref_clk  input  1  reference clock; the only clock.
i_rst_n  input  1  reset, synchronous and active-low.
i_mon_en  input  1  monitor enable.
i_div_clk  input  1  divided clock under test; treated as data and sampled on the posedge of i_ref_clk.
i_exp_ratio  input  RATIO_WIDTH  expected division ratio.
o_valid  output  1  one-cycle pulse when a full period has been measured.
o_high_cnt  output  RATIO_WIDTH  last measured high time, in ref cycles.
o_low_cnt  output  RATIO_WIDTH  last measured low time, in ref cycles.
o_period  output  RATIO_WIDTH+1  last measured period, equal to high plus low.
o_mismatch  output  1  one-cycle pulse, coincident with o_valid, when o_period differs from i_exp_ratio.
o_duty_err  output  1  one-cycle pulse, coincident with o_valid, when the high and low times differ by more than 1.
o_locked  output  1  level; asserted after LOCK_COUNT consecutive matching periods.
o_stall  output  1  level; sticky "no edge" indicator.

Behaviour:
- Reset (i_rst_n low at a posedge): all outputs 0; FSM in IDLE; sync flops s1 and s2 cleared; hi_cnt, lo_cnt and lock_cnt cleared.
- Sampling: s1 <= i_div_clk, then s2 <= s1, every cycle (including while i_mon_en is low).
  - rise = s1 & ~s2.
  - fall = ~s1 & s2.
  - rise and fall are mutually exclusive by construction.
- FSM states: IDLE, HIGH, LOW.
  - IDLE: on rise, go to HIGH with hi_cnt <= 1. Falls are ignored. No publish on the first rise.
  - HIGH: on fall, go to LOW with lo_cnt <= 1. Otherwise hi_cnt <= hi_cnt + 1.
  - LOW: on rise, publish, then hi_cnt <= 1 and go to HIGH. Otherwise lo_cnt <= lo_cnt + 1.
- Publish (registered, visible the cycle after the rise is detected):
  - o_high_cnt <= hi_cnt; o_low_cnt <= lo_cnt.
  - o_period <= zero-extended hi_cnt + lo_cnt.
  - o_valid <= 1 for exactly one cycle; o_stall <= 0.
- Compare on each publish:
  - Enabled only when i_exp_ratio >= 2.
  - Match: lock_cnt increments, saturating at LOCK_COUNT.
  - Mismatch: o_mismatch pulses and lock_cnt <= 0.
  - o_locked = (lock_cnt == LOCK_COUNT), registered.
  - If i_exp_ratio is 0 or 1 (divider bypass): no compare, lock_cnt <= 0, o_locked = 0. A bypassed divider output sampled at the posedge appears constant and produces a stall.
- Duty check: o_duty_err pulses when |hi_cnt - lo_cnt| > 1. Odd ratios (high and low differ by exactly 1) do not flag.
- Stall:
  - Triggers in HIGH with hi_cnt = 2^RATIO_WIDTH-1 and no fall, or in LOW with lo_cnt = 2^RATIO_WIDTH-1 and no rise.
  - Action: FSM goes to IDLE, o_stall <= 1, lock_cnt <= 0, o_locked <= 0.
  - o_stall stays set until the next publish.
  - The half-period counters never wrap.
- i_mon_en low:
  - FSM forced to IDLE; hi_cnt, lo_cnt and lock_cnt cleared.
  - o_valid, o_mismatch, o_duty_err, o_locked and o_stall driven to 0.
  - o_high_cnt, o_low_cnt and o_period hold their values.
  - Re-enable behaves like leaving reset except the sync flops: the first full period after the next rise is measured.
- A change of i_exp_ratio affects only publishes on or after that cycle. A mismatch caused by the change clears lock normally.
- Reset asserted mid-period: the partial measurement is discarded and no publish occurs.

Test Plan:
1. i_exp_ratio=4, i_div_clk toggling 2 high / 2 low -> first o_valid one cycle after the 2nd rise detected; then o_valid every 4 cycles with o_period=4, o_high_cnt=2, o_low_cnt=2; o_locked=1 on the 4th matching publish; no mismatch or duty_err.
2. i_exp_ratio=5, 2 high / 3 low -> o_period=5, o_high_cnt=2, o_low_cnt=3, o_duty_err=0, lock after 4 periods; switch i_exp_ratio to 7 -> o_mismatch pulses and o_locked drops on the next publish.
3. Drive 1 high / 5 low with i_exp_ratio=6 -> o_period=6 matches, o_duty_err pulses every period, lock still achieved.
4. While locked at ratio 4, hold i_div_clk low -> o_stall=1 and o_locked=0 when lo_cnt reaches 31; resume toggling -> o_stall clears on the first publish, which is 2 periods later.
5. Pulse i_rst_n low mid-HIGH, and separately drop i_mon_en mid-LOW -> no o_valid from the partial period; outputs per reset or disable rules; measurement restarts cleanly.
6. i_exp_ratio=0 with i_div_clk stuck at 1 -> never locked, no mismatch, o_stall asserts after 31 cycles in HIGH (following an initial rise).
